// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA-3/SHAKE sponge: state geometry, rate table,
// and the squeeze FSM encoding.
package sha3_pkg;

  localparam int LANE_W   = 64;
  localparam int LANE_CNT = 25;
  localparam int STATE_W  = LANE_W * LANE_CNT;

  // Rate, in 64-bit lanes, for each rate_sel encoding.
  localparam logic [4:0] RATE_SHA3_224  = 5'd18;
  localparam logic [4:0] RATE_SHA3_256  = 5'd17;
  localparam logic [4:0] RATE_SHA3_384  = 5'd13;
  localparam logic [4:0] RATE_SHA3_512  = 5'd9;
  localparam logic [4:0] RATE_SHAKE128  = 5'd21;
  localparam logic [4:0] RATE_SHAKE256  = 5'd17;
  localparam logic [4:0] RATE_RESERVED  = 5'd17;

  // rate_sel encodings
  localparam logic [2:0] SEL_SHA3_224 = 3'b000;
  localparam logic [2:0] SEL_SHA3_256 = 3'b001;
  localparam logic [2:0] SEL_SHA3_384 = 3'b010;
  localparam logic [2:0] SEL_SHA3_512 = 3'b011;
  localparam logic [2:0] SEL_SHAKE128 = 3'b100;
  localparam logic [2:0] SEL_SHAKE256 = 3'b101;

  // Squeeze controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_PERM = 2'd2
  } sq_state_e;

  // Map a rate_sel encoding to the number of rate lanes; the two reserved
  // codes fall back to the SHA3-256 rate.
  function automatic logic [4:0] rate_lanes(input logic [2:0] sel);
    logic [4:0] r;
    case (sel)
      SEL_SHA3_224: r = RATE_SHA3_224;
      SEL_SHA3_256: r = RATE_SHA3_256;
      SEL_SHA3_384: r = RATE_SHA3_384;
      SEL_SHA3_512: r = RATE_SHA3_512;
      SEL_SHAKE128: r = RATE_SHAKE128;
      SEL_SHAKE256: r = RATE_SHAKE256;
      default:      r = RATE_RESERVED;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha3_lane_sel.sv
// Combinational 25:1 lane multiplexer over the 1600-bit Keccak state.
// Lane i = x+5y lives in bits [64i+63:64i]; indices past the last lane
// return zero so callers never see an undefined word.
module sha3_lane_sel
  import sha3_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [4:0]         idx,
  output logic [LANE_W-1:0]  lane
);

  logic [LANE_W-1:0] lanes_s [LANE_CNT];

  for (genvar g = 0; g < LANE_CNT; g++) begin : g_split
    assign lanes_s[g] = state[g*LANE_W +: LANE_W];
  end

  // Pick the addressed lane, guarding against out-of-range indices.
  always_comb begin
    lane = {LANE_W{1'b0}};
    if (idx < 5'(LANE_CNT)) begin
      lane = lanes_s[idx];
    end else begin
      lane = {LANE_W{1'b0}};
    end
  end

endmodule

// File: rtl/sha3_squeeze.sv
// Sponge squeeze engine: streams rate lanes of the captured Keccak state as
// 64-bit words, and hands the state back to the permutation core whenever
// the rate is exhausted while output is still owed.
module sha3_squeeze
  import sha3_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         rate_sel,
  input  logic [15:0]        len_words,
  input  logic [STATE_W-1:0] state_i,
  input  logic               perm_done,
  output logic               perm_req,
  output logic [STATE_W-1:0] state_o,
  output logic [LANE_W-1:0]  dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               busy,
  output logic               done
);

  sq_state_e         fsm_r;
  logic [STATE_W-1:0] state_r;
  logic [4:0]        rate_lanes_r;
  logic [4:0]        lane_idx_r;
  logic [15:0]       remaining_r;

  logic [LANE_W-1:0] dout_r;
  logic              dout_valid_r;
  logic              dout_last_r;
  logic              perm_req_r;
  logic              busy_r;
  logic              done_r;

  logic              beat_s;
  logic [STATE_W-1:0] sel_state_s;
  logic [4:0]        sel_idx_s;
  logic [LANE_W-1:0] next_lane_s;

  assign beat_s = dout_valid_r & dout_ready;

  // dout is registered, so the mux looks one word ahead: lane 0 of the
  // incoming state when capturing (IDLE/PERM), the following lane otherwise.
  always_comb begin
    sel_state_s = state_r;
    sel_idx_s   = lane_idx_r + 5'd1;
    if (fsm_r == ST_OUT) begin
      sel_state_s = state_r;
      sel_idx_s   = lane_idx_r + 5'd1;
    end else begin
      sel_state_s = state_i;
      sel_idx_s   = 5'd0;
    end
  end

  sha3_lane_sel u_lane_sel (
    .state (sel_state_s),
    .idx   (sel_idx_s),
    .lane  (next_lane_s)
  );

  // Squeeze controller with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r        <= ST_IDLE;
      state_r      <= {STATE_W{1'b0}};
      rate_lanes_r <= 5'd0;
      lane_idx_r   <= 5'd0;
      remaining_r  <= 16'd0;
      dout_r       <= {LANE_W{1'b0}};
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      perm_req_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      perm_req_r <= 1'b0;
      done_r     <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (start) begin
            if (len_words != 16'd0) begin
              state_r      <= state_i;
              rate_lanes_r <= rate_lanes(rate_sel);
              remaining_r  <= len_words;
              lane_idx_r   <= 5'd0;
              dout_r       <= next_lane_s;
              dout_valid_r <= 1'b1;
              dout_last_r  <= (len_words == 16'd1);
              busy_r       <= 1'b1;
              fsm_r        <= ST_OUT;
            end else begin
              // Zero-length request completes immediately without output.
              done_r <= 1'b1;
            end
          end
        end

        ST_OUT: begin
          if (beat_s) begin
            remaining_r <= remaining_r - 16'd1;
            if (remaining_r == 16'd1) begin
              lane_idx_r   <= lane_idx_r + 5'd1;
              dout_valid_r <= 1'b0;
              dout_last_r  <= 1'b0;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
              fsm_r        <= ST_IDLE;
            end else if (lane_idx_r == rate_lanes_r - 5'd1) begin
              // Rate exhausted with output still owed: re-permute.
              lane_idx_r   <= 5'd0;
              dout_valid_r <= 1'b0;
              dout_last_r  <= 1'b0;
              perm_req_r   <= 1'b1;
              fsm_r        <= ST_PERM;
            end else begin
              lane_idx_r  <= lane_idx_r + 5'd1;
              dout_r      <= next_lane_s;
              dout_last_r <= (remaining_r == 16'd2);
            end
          end
        end

        ST_PERM: begin
          if (perm_done) begin
            state_r      <= state_i;
            dout_r       <= next_lane_s;
            dout_valid_r <= 1'b1;
            dout_last_r  <= (remaining_r == 16'd1);
            fsm_r        <= ST_OUT;
          end
        end

        default: begin
          fsm_r        <= ST_IDLE;
          dout_valid_r <= 1'b0;
          dout_last_r  <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign state_o    = state_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_last  = dout_last_r;
  assign perm_req   = perm_req_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_sha3_squeeze.sv
// Scoreboard bench for sha3_squeeze: the stimulus side predicts the word
// stream from the sponge rules (word k = lane k mod r of the k div r-th
// state), a monitor pops and compares on every accepted beat.
`timescale 1ns/1ps
module tb_sha3_squeeze;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    rate_sel = 3'd0;
  logic [15:0]   len_words = 16'd0;
  logic [1599:0] state_i = '0;
  logic          perm_done = 1'b0;
  logic          perm_req;
  logic [1599:0] state_o;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;
  logic          busy;
  logic          done;

  sha3_squeeze dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rate_sel   (rate_sel),
    .len_words  (len_words),
    .state_i    (state_i),
    .perm_done  (perm_done),
    .perm_req   (perm_req),
    .state_o    (state_o),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        perm;
  } exp_t;

  exp_t          sb[$];
  logic [1599:0] perm_q[$];

  int errors = 0;
  int checks = 0;
  int perm_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int perm_delay = -1;
  int perm_wait = -1;
  bit auto_perm = 1'b1;
  bit noise_en = 1'b0;
  bit force_done = 1'b0;
  bit noise_start = 1'b0;
  bit chk_after_pd = 1'b0;

  // monitor state
  bit          m_stall = 1'b0;
  bit          m_exp_done = 1'b0;
  bit          m_exp_perm = 1'b0;
  logic [63:0] m_dout = '0;
  logic        m_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_rate(input logic [2:0] sel);
    case (sel)
      3'd0: return 18;
      3'd1: return 17;
      3'd2: return 13;
      3'd3: return 9;
      3'd4: return 21;
      default: return 17;
    endcase
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic [1599:0] pattern_state();
    logic [1599:0] s;
    logic [63:0] base;
    base = 64'h1111_0000_0000_0000;
    for (int i = 0; i < 25; i++) s[64*i +: 64] = base * 64'(i);
    return s;
  endfunction

  task automatic fire_perm_done();
    perm_done = 1'b1;
    if (perm_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL perm_state_queue: got empty expected a pending state");
      state_i = rand_state();
    end else begin
      state_i = perm_q.pop_front();
    end
    perm_wait = -1;
    chk_after_pd = 1'b1;
  endtask

  // Environment: ready pattern, permutation core model, and noise injection.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_after_pd) begin
        chk("valid_after_perm_done", dout_valid, 1);
        chk_after_pd = 1'b0;
      end
      perm_done = 1'b0;
      if (noise_start) begin
        start = 1'b0;
        noise_start = 1'b0;
      end
      case (ready_mode)
        0: dout_ready = 1'b1;
        1: dout_ready = ~dout_ready;
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (force_done) begin
        perm_done = 1'b1;
        state_i = rand_state();
        force_done = 1'b0;
      end else if (perm_wait > 0) begin
        perm_wait--;
        if (perm_wait == 0) fire_perm_done();
      end else if (perm_req && auto_perm) begin
        perm_wait = (perm_delay < 0) ? int'($urandom_range(0, 3)) : perm_delay;
        if (perm_wait == 0) fire_perm_done();
      end else if (noise_en && dout_valid && !dout_last) begin
        if ($urandom_range(0, 3) == 0) begin
          perm_done = 1'b1;
          state_i = rand_state();
        end else if ($urandom_range(0, 5) == 0) begin
          start = 1'b1;
          noise_start = 1'b1;
          rate_sel = 3'($urandom);
          len_words = 16'($urandom);
          state_i = rand_state();
        end
      end
    end
  end

  // Monitor: compare every accepted beat against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_stall = 1'b0;
        m_exp_done = 1'b0;
        m_exp_perm = 1'b0;
      end else begin
        if (m_exp_done) begin
          chk("done_pulse", done, 1);
          chk("busy_drop", busy, 0);
          m_exp_done = 1'b0;
        end
        if (m_exp_perm) begin
          chk("perm_req_pulse", perm_req, 1);
          chk("valid_low_in_perm", dout_valid, 0);
          m_exp_perm = 1'b0;
        end
        if (dout_last) chk("last_needs_valid", dout_valid, 1);
        if (m_stall) begin
          chk("stall_valid", dout_valid, 1);
          chk("stall_dout", dout, m_dout);
          chk("stall_last", dout_last, m_last);
        end
        if (dout_valid && dout_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected no beat", dout);
          end else begin
            e = sb.pop_front();
            chk("dout", dout, e.data);
            chk("dout_last", dout_last, e.last);
            m_exp_done = e.last;
            m_exp_perm = e.perm;
          end
        end
        if (perm_req) perm_cnt++;
        if (done) done_cnt++;
        m_stall = dout_valid && !dout_ready;
        m_dout = dout;
        m_last = dout_last;
      end
    end
  end

  task automatic run_txn(input logic [2:0] sel, input int len, input logic [1599:0] init,
                         input int rmode, input bit noise, input int pdelay);
    int r, n_perm, cyc, pc0, dc0;
    logic [1599:0] cur;
    logic [1599:0] states[$];
    exp_t e;
    r = model_rate(sel);
    n_perm = (len > 0) ? (len - 1) / r : 0;
    states.push_back(init);
    for (int p = 0; p < n_perm; p++) begin
      cur = rand_state();
      states.push_back(cur);
      perm_q.push_back(cur);
    end
    for (int k = 0; k < len; k++) begin
      cur = states[k / r];
      e.data = cur[64*(k % r) +: 64];
      e.last = (k == len - 1);
      e.perm = ((k % r) == r - 1) && (k != len - 1);
      sb.push_back(e);
    end
    ready_mode = rmode;
    perm_delay = pdelay;
    pc0 = perm_cnt;
    dc0 = done_cnt;
    @(posedge clk);
    #2;
    start = 1'b1;
    rate_sel = sel;
    len_words = len[15:0];
    state_i = init;
    @(posedge clk);
    #2;
    start = 1'b0;
    rate_sel = 3'($urandom);
    len_words = 16'($urandom);
    @(negedge clk);
    if (len > 0) begin
      chk("first_valid", dout_valid, 1);
      chk("busy_high", busy, 1);
    end else begin
      chk("zero_len_done", done, 1);
      chk("zero_len_valid", dout_valid, 0);
      chk("zero_len_busy", busy, 0);
    end
    noise_en = noise;
    cyc = 0;
    while ((sb.size() != 0 || busy) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    noise_en = 1'b0;
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got %0d words left expected 0", sb.size());
      sb.delete();
    end
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("perm_count", 64'(perm_cnt - pc0), 64'(n_perm));
    chk("done_count", 64'(done_cnt - dc0), 64'd1);
    perm_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_last"}, dout_last, 0);
    chk({tag, "_perm_req"}, perm_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state_o"}, 64'(|state_o), 0);
  endtask

  initial begin
    int cyc;
    logic [1599:0] st;
    exp_t e;

    // Power-on reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // SHA3-256, four words, no permutation
    run_txn(3'b001, 4, pattern_state(), 0, 1'b0, -1);
    // SHAKE128, 23 words, one permutation 3 cycles after the request
    run_txn(3'b100, 23, rand_state(), 0, 1'b0, 3);
    // SHA3-512 with toggling backpressure, length equal to the rate
    run_txn(3'b011, 9, rand_state(), 1, 1'b0, -1);
    // Zero-length request
    run_txn(3'b001, 0, rand_state(), 0, 1'b0, -1);
    // Reserved rate code with spurious perm_done / start noise
    run_txn(3'b111, 20, rand_state(), 2, 1'b1, -1);
    // Minimum permutation wait
    run_txn(3'b011, 30, rand_state(), 0, 1'b0, 0);

    // Reset while waiting on the permutation core
    auto_perm = 1'b0;
    st = rand_state();
    for (int k = 0; k < 21; k++) begin
      e.data = st[64*k +: 64];
      e.last = 1'b0;
      e.perm = (k == 20);
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
    start = 1'b1;
    rate_sel = 3'b100;
    len_words = 16'd30;
    state_i = st;
    @(posedge clk);
    #2;
    start = 1'b0;
    cyc = 0;
    while (!perm_req && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_perm", perm_req, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check_outputs_zero("after_reset");
    force_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("late_perm_valid", dout_valid, 0);
      chk("late_perm_busy", busy, 0);
    end
    auto_perm = 1'b1;
    run_txn(3'b101, 5, rand_state(), 0, 1'b0, -1);

    // Randomized transactions
    for (int t = 0; t < 10; t++) begin
      run_txn(3'($urandom_range(0, 7)), int'($urandom_range(1, 60)), rand_state(),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha3_squeeze.md
# sha3_squeeze

Sponge squeeze engine for the SHA-3/SHAKE core. It takes the 1600-bit Keccak state after the final absorb permutation and streams rate lanes out as 64-bit words over a valid/ready interface. When the rate portion is exhausted and more output is still owed, it hands the state back to the permutation core and waits for the result. It is the consumer/reader end of the same 25-lane state bus that the round logic (theta and the other step functions) produces.

## Interface
- Lane layout on every 1600-bit bus: lane i = x+5y occupies bits [64i+63:64i].
- Parameters: none. Lane width is fixed at 64 by the state format.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE; captures state_i, rate_sel and len_words.
- rate_sel  in  3  rate in lanes:
  - 000 = 18 (SHA3-224), 001 = 17 (SHA3-256), 010 = 13 (SHA3-384), 011 = 9 (SHA3-512)
  - 100 = 21 (SHAKE128), 101 = 17 (SHAKE256)
  - 110/111 reserved; treated as 17
- len_words  in  16  number of 64-bit output words to emit; the consumer truncates partial words.
- state_i  in  1600  state from the permutation core; captured on start, or on perm_done while in PERM.
- perm_done  in  1  one-cycle pulse from the permutation core: state_i is valid.
- perm_req  out  1  one-cycle pulse: permute state_o.
- state_o  out  1600  held state register; stable while in PERM.
- dout  out  64  current output lane.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  downstream accepts dout.
- dout_last  out  1  qualifies the final word; high only together with dout_valid.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final word is accepted.

## Operation
- FSM states: IDLE, OUT, PERM.
- IDLE + start, len_words>0:
  - capture state_i into the state register, the rate into rate_lanes, len_words into remaining
  - lane_idx=0; go to OUT.
- IDLE + start, len_words==0: stay in IDLE; pulse done on the next cycle; dout_valid stays low.
- OUT:
  - dout = lane[lane_idx] of the state register; dout_valid=1; dout_last=(remaining==1).
  - A beat is dout_valid&&dout_ready; each beat decrements remaining and increments lane_idx.
  - Beat with remaining==1: go to IDLE; pulse done.
  - Otherwise, beat with lane_idx==rate_lanes-1: lane_idx wraps to 0; go to PERM.
- PERM:
  - perm_req is high for exactly the first cycle after entry; dout_valid=0.
  - On perm_done: capture state_i; go to OUT.
- perm_done outside PERM is ignored. start outside IDLE is ignored. rate_sel and len_words are ignored after capture.
- dout, dout_last and dout_valid must hold stable while dout_valid && !dout_ready.
- Reset (async, any state): FSM to IDLE; state register, lane_idx and remaining cleared; all outputs 0. An in-flight permutation result arriving after reset is ignored.

## Timing
- start at edge N → dout_valid=1 in cycle N+1 carrying lane 0. No combinational path from start to dout.
- Back-to-back beats with dout_ready held high: one word per cycle.
- Rate exhaustion: the last rate lane is accepted at edge M → perm_req=1 in cycle M+1 and dout_valid=0.
- perm_done at edge K → dout_valid=1 in cycle K+1 carrying lane 0 of the new state.
- done is asserted in the cycle after the final beat. busy drops in that same cycle.
- Minimum permutation wait is 1 cycle: perm_done coincident with the perm_req cycle is accepted.

## Structure
- Shared package sha3_pkg holds:
  - LANE_W=64 and the lane count 25
  - rate constants for each rate_sel encoding
  - function rate_lanes(sel) returning 5 bits
  - the FSM state enum
- Sub-module sha3_lane_sel: combinational 25:1 64-bit lane mux (state, index → lane), reusable by the absorb path.
- Counters: lane_idx is 5 bits; remaining is 16 bits.

## Test plan
- SHA3-256 (001), len=4, lane i = 64'h1111_0000_0000_0000*i pattern, dout_ready=1:
  - 4 consecutive words, lanes 0..3; dout_last on the 4th
  - done one cycle later; perm_req never asserted.
- SHAKE128 (100), len=23, ready=1:
  - 21 words, then perm_req pulse
  - perm_done 3 cycles later with a new state
  - lanes 0,1 of the new state, last on the 2nd; 23 total beats.
- Backpressure: SHA3-512, len=9, dout_ready toggling 1-0-1:
  - dout stable during stalls; exactly 9 beats
  - no perm_req, since len equals the 9-lane rate.
- len_words=0 with start: done pulses the next cycle; no dout_valid; busy stays 0.
- Robustness:
  - spurious perm_done in OUT is ignored, with no state change
  - start during OUT is ignored
  - rate_sel=111 behaves as 17 lanes (perm_req after the 17th word with len=20).
- Reset mid-operation:
  - rst_n low for 1 cycle during PERM → all outputs 0, FSM in IDLE
  - a later perm_done produces no output; a new start works normally.
